aoi_exp_pipe: RTL and testbench
===============================

// Module: aoi_exp_pipe
// PURPOSE
//   Parametrised, pipelined AND-OR-INVERT gate with expander chaining. Successor to the
//   single 2x2-AOI expander gate.
//   NUM_TERMS AND terms of TERM_WIDTH inputs each, plus an X/XBAR expander pair, give
//   Y = ~(OR(enabled terms) | EXP_X | ~EXP_XBAR).
//   Adds valid/ready flow control, a 2-cycle register pipeline, a run-time term-enable mask
//   and a saturating counter of low-Y results.
//   Used in the TI-products library wherever an AOI with more or wider terms is chained.
// PARAMETERS
//   NUM_TERMS   4   number of AND terms (>=1)
//   TERM_WIDTH  2   inputs per AND term (>=1)
//   CNT_WIDTH   8   width of HIT_COUNT
// PORTS
//   CLK        in   1                     clock, all state on rising edge
//   RST        in   1                     synchronous, active-high reset
//   IN_VALID   in   1                     TERM_IN/EXP_X/EXP_XBAR valid
//   IN_READY   out  1                     stage 1 can accept this cycle
//   TERM_IN    in   NUM_TERMS*TERM_WIDTH  term t = bits [t*TERM_WIDTH +: TERM_WIDTH]
//   EXP_X      in   1                     expander X from upstream gate (active high)
//   EXP_XBAR   in   1                     expander XBAR from upstream gate (active low)
//   CFG_WE     in   1                     load CFG_MASK into the term-enable mask
//   CFG_MASK   in   NUM_TERMS             1 = term t participates
//   COUNT_CLR  in   1                     clear HIT_COUNT
//   OUT_VALID  out  1                     Y/X_OUT/XBAR_OUT valid
//   OUT_READY  in   1                     downstream accepts result
//   Y          out  1                     registered AOI result
//   X_OUT      out  1                     registered OR of enabled terms | EXP_X | ~EXP_XBAR
//   XBAR_OUT   out  1                     ~X_OUT, for chaining into a further expander input
//   HIT_COUNT  out  CNT_WIDTH             number of accepted results with Y==0
// BEHAVIOUR
//   Reset values:
//     - OUT_VALID=0, Y=1, X_OUT=0, XBAR_OUT=1, HIT_COUNT=0, mask = all ones.
//     - All pipeline valid bits are cleared; in-flight data is discarded.
//   Stage 1:
//     - On IN_VALID & IN_READY, register term_and[t] = &TERM_IN[t] & mask[t], EXP_X and EXP_XBAR.
//     - Set s1_valid.
//   Stage 2:
//     - Register x = |term_and | EXP_X | ~EXP_XBAR, and drive Y=~x, X_OUT=x, XBAR_OUT=~x.
//     - Set OUT_VALID.
//   Latency: 2 cycles from the accept edge to OUT_VALID when there is no backpressure.
//   Throughput: 1 result per cycle.
//   Flow control:
//     - s2 loads when ~OUT_VALID | OUT_READY.
//     - s1 advances into s2 under the same condition.
//     - IN_READY = ~s1_valid | (~OUT_VALID | OUT_READY). It is combinational and does not
//       depend on IN_VALID.
//   Holding rules:
//     - While OUT_VALID & ~OUT_READY, Y/X_OUT/XBAR_OUT and OUT_VALID hold unchanged.
//     - Stage 1 holds if it is full.
//   Bubbles: OUT_VALID drops the cycle after a transfer if s1 is empty. No duplicate or
//     lost results.
//   Mask:
//     - CFG_WE takes effect for captures on the cycle after the write.
//     - A capture on the same edge as CFG_WE uses the old mask.
//     - In-flight entries are unaffected.
//   Mask all zero: Y depends only on the expander pair, giving Y = ~(EXP_X | ~EXP_XBAR).
//   HIT_COUNT:
//     - Increments on OUT_VALID & OUT_READY & ~Y.
//     - Saturates at 2**CNT_WIDTH-1; no wrap.
//     - COUNT_CLR has priority over an increment on the same edge; the result is 0.
//   Reset mid-operation: RST wins over every other input on that edge. The next cycle is
//     identical to post-reset.
// TESTING
//   T1 defaults, TERM_IN=8'b0000_0011, EXP_X=0, EXP_XBAR=1, IN_VALID=1 for 1 cycle:
//      -> OUT_VALID 2 cycles later, Y=0, X_OUT=1, XBAR_OUT=0, HIT_COUNT=1.
//   T2 TERM_IN=8'b0101_0101, EXP_X=0, EXP_XBAR=1 -> Y=1, X_OUT=0.
//      Repeat with EXP_XBAR=0 -> Y=0.
//      Repeat with EXP_X=1 -> Y=0.
//   T3 CFG_WE with CFG_MASK=4'b1110 at the same edge as a capture of TERM_IN=8'h03
//      -> that result has Y=0 (old mask). The next capture of 8'h03 -> Y=1.
//   T4 stream 6 back-to-back inputs, OUT_READY low for cycles 3-5:
//      -> IN_READY low once s1 and s2 are full.
//      -> all 6 results are delivered in order, none dropped or repeated.
//   T5 CNT_WIDTH=2, 5 accepted Y=0 results -> HIT_COUNT saturates at 3.
//      COUNT_CLR together with a Y=0 transfer -> HIT_COUNT=0.
//   T6 assert RST with both stages full and OUT_READY=0:
//      -> next cycle OUT_VALID=0, Y=1, X_OUT=0, HIT_COUNT=0, mask=4'b1111.

Source files
------------

// File: rtl/aoi_exp_pipe.sv
// Pipelined AND-OR-INVERT gate with expander chaining, a term-enable mask and a low-Y counter.
// Latency: 2 register stages (accept edge -> stage 1, next edge -> outputs), 1 result per cycle.
// Backpressure: outputs hold while OUT_VALID & ~OUT_READY; IN_READY drops only when both stages are full.
//
// Ports:
//   CLK, RST                   clock and synchronous active-high reset
//   IN_VALID/IN_READY          input handshake for TERM_IN, EXP_X, EXP_XBAR
//   TERM_IN                    NUM_TERMS packed AND terms, TERM_WIDTH bits each
//   EXP_X/EXP_XBAR             expander pair from an upstream gate
//   CFG_WE/CFG_MASK            term-enable mask load
//   COUNT_CLR                  clears HIT_COUNT
//   OUT_VALID/OUT_READY        output handshake for Y, X_OUT, XBAR_OUT
//   HIT_COUNT                  saturating count of delivered results with Y == 0
module aoi_exp_pipe #(
  parameter int NUM_TERMS  = 4,
  parameter int TERM_WIDTH = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            IN_VALID,
  output logic                            IN_READY,
  input  logic [NUM_TERMS*TERM_WIDTH-1:0] TERM_IN,
  input  logic                            EXP_X,
  input  logic                            EXP_XBAR,
  input  logic                            CFG_WE,
  input  logic [NUM_TERMS-1:0]            CFG_MASK,
  input  logic                            COUNT_CLR,
  output logic                            OUT_VALID,
  input  logic                            OUT_READY,
  output logic                            Y,
  output logic                            X_OUT,
  output logic                            XBAR_OUT,
  output logic [CNT_WIDTH-1:0]            HIT_COUNT
);

  logic [NUM_TERMS-1:0] mask;
  logic [NUM_TERMS-1:0] term_and;

  logic                 s1_valid;
  logic [NUM_TERMS-1:0] s1_term_and;
  logic                 s1_exp_x;
  logic                 s1_exp_xbar;

  logic                 x_q;

  logic                 s2_advance;
  logic                 s1_accept;
  logic                 out_xfer;
  logic                 count_sat;

  // Stage 2 is free to load whenever it is empty or being drained this cycle.
  assign s2_advance = ~OUT_VALID | OUT_READY;
  assign IN_READY   = ~s1_valid | s2_advance;
  assign s1_accept  = IN_VALID & IN_READY;
  assign out_xfer   = OUT_VALID & OUT_READY;
  assign count_sat  = &HIT_COUNT;

  // Term products use the mask as registered before this edge, so a capture
  // coinciding with CFG_WE still sees the old mask.
  always_comb begin
    term_and = '0;
    for (int t = 0; t < NUM_TERMS; t++) begin
      term_and[t] = (&TERM_IN[t*TERM_WIDTH +: TERM_WIDTH]) & mask[t];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mask <= '1;
    end else if (CFG_WE) begin
      mask <= CFG_MASK;
    end
  end

  // Stage 1: captured term products and expander pair.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid    <= 1'b0;
      s1_term_and <= '0;
      s1_exp_x    <= 1'b0;
      s1_exp_xbar <= 1'b1;
    end else if (s1_accept) begin
      s1_valid    <= 1'b1;
      s1_term_and <= term_and;
      s1_exp_x    <= IN_VALID ? EXP_X : s1_exp_x;
      s1_exp_xbar <= EXP_XBAR;
    end else if (s2_advance) begin
      s1_valid    <= 1'b0;
    end
  end

  // Stage 2: the OR reduction. Data only updates when a real entry moves in,
  // so the last result stays on the outputs through a bubble.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      x_q       <= 1'b0;
    end else if (s2_advance) begin
      OUT_VALID <= s1_valid;
      if (s1_valid) begin
        x_q <= (|s1_term_and) | s1_exp_x | ~s1_exp_xbar;
      end
    end
  end

  assign X_OUT    = x_q;
  assign Y        = ~x_q;
  assign XBAR_OUT = ~x_q;

  // Counts delivered low-Y results; clear beats increment, no wrap at the top.
  always_ff @(posedge CLK) begin
    if (RST) begin
      HIT_COUNT <= '0;
    end else if (COUNT_CLR) begin
      HIT_COUNT <= '0;
    end else if (out_xfer & ~Y & ~count_sat) begin
      HIT_COUNT <= HIT_COUNT + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_aoi_exp_pipe.sv
module tb_aoi_exp_pipe;

  localparam int NT = 4;
  localparam int TW = 2;
  localparam int CW = 2;
  localparam int CMAX = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [NT*TW-1:0] TERM_IN = '0;
  logic          EXP_X = 1'b0;
  logic          EXP_XBAR = 1'b1;
  logic          CFG_WE = 1'b0;
  logic [NT-1:0] CFG_MASK = '0;
  logic          COUNT_CLR = 1'b0;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b1;
  logic          Y;
  logic          X_OUT;
  logic          XBAR_OUT;
  logic [CW-1:0] HIT_COUNT;

  always #5 CLK = ~CLK;

  aoi_exp_pipe #(.NUM_TERMS(NT), .TERM_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .TERM_IN(TERM_IN), .EXP_X(EXP_X), .EXP_XBAR(EXP_XBAR),
    .CFG_WE(CFG_WE), .CFG_MASK(CFG_MASK), .COUNT_CLR(COUNT_CLR),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .Y(Y), .X_OUT(X_OUT), .XBAR_OUT(XBAR_OUT), .HIT_COUNT(HIT_COUNT)
  );

  int total = 0;
  int bad = 0;

  // Reference state: results in flight, delivered results paired with the
  // model's expectation, the mask and the counter.
  logic [2:0] exp_q[$];
  logic [2:0] got_q[$];
  logic [2:0] want_q[$];
  logic [NT-1:0] m_mask = '1;
  int m_cnt = 0;

  // Result packed as {y, x, xbar}.
  function automatic logic [2:0] ref_res(input logic [7:0] ti, input logic ex,
                                         input logic exb, input logic [3:0] mk);
    bit hit;
    hit = 0;
    for (int t = 0; t < NT; t++)
      if (mk[t] && ti[2*t] && ti[2*t+1]) hit = 1;
    if (hit || ex || !exb) return 3'b010;
    return 3'b101;
  endfunction

  // One clock: sample the handshakes with settled inputs, update the model,
  // cross the edge and leave time 1 unit after it.
  task automatic step();
    logic xfer, acc;
    logic [2:0] w;
    #1;
    xfer = OUT_VALID && OUT_READY;
    acc  = IN_VALID && IN_READY;
    if (RST) begin
      exp_q.delete();
      m_mask = '1;
      m_cnt = 0;
    end else begin
      if (xfer) begin
        w = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
        got_q.push_back({Y, X_OUT, XBAR_OUT});
        want_q.push_back(w);
        if (COUNT_CLR) m_cnt = 0;
        else if (w[2] === 1'b0 && m_cnt < CMAX) m_cnt++;
      end else if (COUNT_CLR) begin
        m_cnt = 0;
      end
      if (acc) exp_q.push_back(ref_res(TERM_IN, EXP_X, EXP_XBAR, m_mask));
      if (CFG_WE) m_mask = CFG_MASK;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(output bit ok);
    IN_VALID = 0;
    OUT_READY = 1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && !OUT_VALID) begin
        ok = 1;
        break;
      end
      step();
    end
    if (exp_q.size() == 0 && !OUT_VALID) ok = 1;
  endtask

  task automatic send(input logic [7:0] ti, input logic ex, input logic exb);
    TERM_IN = ti; EXP_X = ex; EXP_XBAR = exb; IN_VALID = 1;
    step();
    IN_VALID = 0;
  endtask

  task automatic test_reset();
    RST = 1;
    step(); step();
    RST = 0;
    got_q.delete(); want_q.delete();
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", OUT_VALID); end
    total++; if ({Y, X_OUT, XBAR_OUT} !== 3'b101) begin bad++; $display("FAIL reset_outputs got=%b want=101", {Y, X_OUT, XBAR_OUT}); end
    total++; if (HIT_COUNT !== 2'd0) begin bad++; $display("FAIL reset_hit_count got=%0d want=0", HIT_COUNT); end
    total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", IN_READY); end
  endtask

  task automatic test_latency();
    logic [2:0] g, w;
    OUT_READY = 1;
    send(8'h03, 1'b0, 1'b1);
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL lat_early_valid got=%b want=0", OUT_VALID); end
    step();
    total++; if (OUT_VALID !== 1'b1) begin bad++; $display("FAIL lat_valid got=%b want=1", OUT_VALID); end
    total++; if ({Y, X_OUT, XBAR_OUT} !== 3'b010) begin bad++; $display("FAIL lat_result got=%b want=010", {Y, X_OUT, XBAR_OUT}); end
    step();
    total++; if (HIT_COUNT !== 2'd1) begin bad++; $display("FAIL lat_hit_count got=%0d want=1", HIT_COUNT); end
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL lat_bubble got=%b want=0", OUT_VALID); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); w = want_q.pop_front();
      total++; if (g !== w) begin bad++; $display("FAIL lat_model got=%b want=%b", g, w); end
    end
  endtask

  task automatic test_patterns();
    logic [7:0] ti[3] = '{8'h55, 8'h55, 8'h55};
    logic ex[3]  = '{1'b0, 1'b0, 1'b1};
    logic exb[3] = '{1'b1, 1'b0, 1'b1};
    logic y[3]   = '{1'b1, 1'b0, 1'b0};
    logic [2:0] g, w;
    for (int i = 0; i < 3; i++) begin
      send(ti[i], ex[i], exb[i]);
      step();
      total++; if (OUT_VALID !== 1'b1 || Y !== y[i] || X_OUT !== ~y[i]) begin
        bad++; $display("FAIL pattern%0d got v=%b y=%b x=%b want v=1 y=%b", i, OUT_VALID, Y, X_OUT, y[i]);
      end
      step();
    end
    total++; if (HIT_COUNT !== CW'(m_cnt)) begin bad++; $display("FAIL pattern_count got=%0d want=%0d", HIT_COUNT, m_cnt); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); w = want_q.pop_front();
      total++; if (g !== w) begin bad++; $display("FAIL pattern_model got=%b want=%b", g, w); end
    end
  endtask

  task automatic test_mask();
    bit ok;
    logic [2:0] g, w;
    logic ye;
    TERM_IN = 8'h03; EXP_X = 0; EXP_XBAR = 1; IN_VALID = 1;
    CFG_WE = 1; CFG_MASK = 4'b1110;
    step();
    CFG_WE = 0;
    step();
    drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL mask_drain_timeout got=busy want=idle"); end
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL mask_count got=%0d want=2", got_q.size()); end
    if (got_q.size() == 2) begin
      total++; if (got_q[0][2] !== 1'b0) begin bad++; $display("FAIL mask_old_y got=%b want=0", got_q[0][2]); end
      total++; if (got_q[1][2] !== 1'b1) begin bad++; $display("FAIL mask_new_y got=%b want=1", got_q[1][2]); end
    end
    got_q.delete(); want_q.delete();
    // All-zero mask: only the expander pair matters.
    CFG_WE = 1; CFG_MASK = 4'b0000;
    step();
    CFG_WE = 0;
    for (int k = 0; k < 4; k++) begin
      send(8'hFF, k[1], k[0]);
      drain(ok);
      ye = ~(k[1] | ~k[0]);
      g = got_q.pop_front(); w = want_q.pop_front();
      total++; if (g[2] !== ye || g !== w) begin bad++; $display("FAIL mask_zero%0d got=%b want_y=%b model=%b", k, g, ye, w); end
    end
    CFG_WE = 1; CFG_MASK = 4'b1111;
    step();
    CFG_WE = 0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] items[6];
    logic [2:0] g, w;
    int sent = 0;
    bit done = 0;
    logic ir;
    for (int i = 0; i < 6; i++) items[i] = 8'($urandom);
    for (int c = 0; c < 40 && !done; c++) begin
      OUT_READY = !(c >= 3 && c <= 5);
      IN_VALID = (sent < 6);
      TERM_IN = items[sent < 6 ? sent : 5];
      EXP_X = 0; EXP_XBAR = 1;
      #1;
      ir = IN_READY;
      if (c >= 3 && c <= 5) begin
        total++; if (ir !== 1'b0) begin bad++; $display("FAIL b2b_in_ready_c%0d got=%b want=0", c, ir); end
      end
      if (c == 6) begin
        total++; if (ir !== 1'b1) begin bad++; $display("FAIL b2b_in_ready_c6 got=%b want=1", ir); end
      end
      if (IN_VALID && ir) sent++;
      step();
      IN_VALID = 0;
      if (sent == 6 && exp_q.size() == 0 && !OUT_VALID) done = 1;
    end
    OUT_READY = 1;
    total++; if (!done) begin bad++; $display("FAIL b2b_timeout got=sent%0d want=idle", sent); end
    total++; if (got_q.size() != 6) begin bad++; $display("FAIL b2b_count got=%0d want=6", got_q.size()); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); w = want_q.pop_front();
      total++; if (g !== w) begin bad++; $display("FAIL b2b_order got=%b want=%b", g, w); end
    end
  endtask

  task automatic test_saturation();
    bit ok;
    COUNT_CLR = 1; step(); COUNT_CLR = 0;
    total++; if (HIT_COUNT !== 2'd0) begin bad++; $display("FAIL sat_clear got=%0d want=0", HIT_COUNT); end
    TERM_IN = 8'h03; EXP_X = 0; EXP_XBAR = 1; IN_VALID = 1;
    repeat (5) step();
    drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL sat_drain_timeout got=busy want=idle"); end
    total++; if (HIT_COUNT !== 2'd3) begin bad++; $display("FAIL sat_value got=%0d want=3", HIT_COUNT); end
    send(8'h03, 1'b0, 1'b1);
    step();
    COUNT_CLR = 1;
    step();
    COUNT_CLR = 0;
    total++; if (HIT_COUNT !== 2'd0) begin bad++; $display("FAIL sat_clr_priority got=%0d want=0", HIT_COUNT); end
    total++; if (got_q.size() != 6) begin bad++; $display("FAIL sat_results got=%0d want=6", got_q.size()); end
    got_q.delete(); want_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [2:0] g;
    send(8'h00, 1'b1, 1'b1);
    drain(ok);
    CFG_WE = 1; CFG_MASK = 4'b0000; step(); CFG_WE = 0;
    OUT_READY = 0;
    TERM_IN = 8'h55; IN_VALID = 1;
    step(); step();
    IN_VALID = 0;
    total++; if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0) begin
      bad++; $display("FAIL rstmid_full got v=%b rdy=%b want v=1 rdy=0", OUT_VALID, IN_READY);
    end
    RST = 1; IN_VALID = 1; CFG_WE = 1; CFG_MASK = 4'b0000;
    step();
    RST = 0; IN_VALID = 0; CFG_WE = 0;
    got_q.delete(); want_q.delete();
    total++; if ({OUT_VALID, Y, X_OUT, XBAR_OUT} !== 4'b0101) begin
      bad++; $display("FAIL rstmid_outputs got=%b want=0101", {OUT_VALID, Y, X_OUT, XBAR_OUT});
    end
    total++; if (HIT_COUNT !== 2'd0) begin bad++; $display("FAIL rstmid_count got=%0d want=0", HIT_COUNT); end
    OUT_READY = 1;
    step();
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL rstmid_discard got=%b want=0", OUT_VALID); end
    send(8'h03, 1'b0, 1'b1);
    drain(ok);
    g = (got_q.size() > 0) ? got_q.pop_front() : 3'bxxx;
    total++; if (g !== 3'b010) begin bad++; $display("FAIL rstmid_mask got=%b want=010", g); end
    got_q.delete(); want_q.delete();
  endtask

  task automatic test_random();
    bit ok;
    logic [2:0] g, w;
    for (int c = 0; c < 300; c++) begin
      IN_VALID  = ($urandom % 4) != 0;
      TERM_IN   = 8'($urandom);
      EXP_X     = ($urandom % 8) == 0;
      EXP_XBAR  = ($urandom % 8) != 0;
      OUT_READY = ($urandom % 3) != 0;
      CFG_WE    = ($urandom % 16) == 0;
      CFG_MASK  = 4'($urandom);
      COUNT_CLR = ($urandom % 32) == 0;
      step();
      if (c % 10 == 0) begin
        total++; if (HIT_COUNT !== CW'(m_cnt)) begin bad++; $display("FAIL rand_count_c%0d got=%0d want=%0d", c, HIT_COUNT, m_cnt); end
      end
    end
    CFG_WE = 0; COUNT_CLR = 0;
    drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL rand_drain_timeout got=busy want=idle"); end
    total++; if (HIT_COUNT !== CW'(m_cnt)) begin bad++; $display("FAIL rand_final_count got=%0d want=%0d", HIT_COUNT, m_cnt); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); w = want_q.pop_front();
      total++; if (g !== w) begin bad++; $display("FAIL rand_result got=%b want=%b", g, w); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_patterns();
    test_mask();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
